// File: rtl/issue_scoreboard_if.sv
// Issue-stage bus: dispatch-queue head on one side, execution handshake on the other.
// Handshake rule: iss_instr transfers on a rising edge where iss_valid && iss_ready;
// once iss_valid is raised, iss_valid and iss_instr stay stable until that transfer
// (a flush or a reset may drop iss_valid without a transfer).
`ifndef DE_instr_width
`define DE_instr_width 32
`endif

interface issue_scoreboard_if #(
    parameter int W = `DE_instr_width
) ();
    logic         dq_empty;
    logic [W-1:0] dq_instr;
    logic         dq_r_en;
    logic         iss_valid;
    logic         iss_ready;
    logic [W-1:0] iss_instr;

    // Environment side: owns the dispatch queue and the execution unit
    modport master (
        output dq_empty, dq_instr, iss_ready,
        input  dq_r_en, iss_valid, iss_instr
    );

    // Issue stage side
    modport slave (
        input  dq_empty, dq_instr, iss_ready,
        output dq_r_en, iss_valid, iss_instr
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue stage: pops the dispatch-queue head when it has no RAW/WAW hazard
// against the busy scoreboard and the one-entry output register can take it.
// A writeback landing in the same cycle is bypassed, so a waiting consumer pops in
// the producer's writeback cycle.
`ifndef DE_instr_width
`define DE_instr_width 32
`endif

module issue_scoreboard #(
    parameter int INSTR_W     = `DE_instr_width,
    parameter int RD_LSB      = 7,
    parameter int RS1_LSB     = 15,
    parameter int RS2_LSB     = 20,
    parameter int HAS_RD_BIT  = INSTR_W - 1,
    parameter int HAS_RS1_BIT = INSTR_W - 2,
    parameter int HAS_RS2_BIT = INSTR_W - 3
) (
    input  logic                clk,
    input  logic                rst_n,
    issue_scoreboard_if.slave   bus,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic                flush,
    output logic [15:0]         stall_cnt,
    output logic [31:0]         dbg_busy
);

    logic [31:0]        r_busy;
    logic               r_iss_valid;
    logic [INSTR_W-1:0] r_iss_instr;
    logic [15:0]        r_stall_cnt;

    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_has_rd;
    logic        w_has_rs1;
    logic        w_has_rs2;
    logic [31:0] w_busy_eff;
    logic [31:0] w_busy_nxt;
    logic        w_hazard;
    logic        w_can_load;
    logic        w_pop;
    logic        w_stall;

    assign w_rd      = bus.dq_instr[RD_LSB  +: 5];
    assign w_rs1     = bus.dq_instr[RS1_LSB +: 5];
    assign w_rs2     = bus.dq_instr[RS2_LSB +: 5];
    assign w_has_rd  = bus.dq_instr[HAS_RD_BIT];
    assign w_has_rs1 = bus.dq_instr[HAS_RS1_BIT];
    assign w_has_rs2 = bus.dq_instr[HAS_RS2_BIT];

    // Busy view used for hazard checks: a writeback in this cycle already frees its register
    always_comb begin
        w_busy_eff = r_busy;
        if (wb_valid) begin
            w_busy_eff[wb_rd] = 1'b0;
        end
        w_busy_eff[0] = 1'b0;
    end

    assign w_hazard   = (w_has_rs1 & w_busy_eff[w_rs1]) |
                        (w_has_rs2 & w_busy_eff[w_rs2]) |
                        (w_has_rd  & w_busy_eff[w_rd]);
    assign w_can_load = ~r_iss_valid | bus.iss_ready;
    // rst_n gates the pop so the queue is never drained while the stage is held in reset
    assign w_pop      = rst_n & ~bus.dq_empty & ~w_hazard & w_can_load & ~flush;
    assign w_stall    = ~bus.dq_empty & ~w_pop & ~flush;

    // Next scoreboard: flush wipes everything; otherwise clear on writeback, then a new
    // producer of the same register overrides that clear
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (wb_valid) begin
                w_busy_nxt[wb_rd] = 1'b0;
            end
            if (w_pop && w_has_rd) begin
                w_busy_nxt[w_rd] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Output slot: load on pop, empty on handshake without reload, drop on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid <= 1'b0;
            r_iss_instr <= '0;
        end else if (flush) begin
            r_iss_valid <= 1'b0;
        end else if (w_pop) begin
            r_iss_valid <= 1'b1;
            r_iss_instr <= bus.dq_instr;
        end else if (r_iss_valid && bus.iss_ready) begin
            r_iss_valid <= 1'b0;
        end
    end

    // Saturating count of cycles where a waiting head entry could not issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.dq_r_en   = w_pop;
    assign bus.iss_valid = r_iss_valid;
    assign bus.iss_instr = r_iss_instr;
    assign stall_cnt     = r_stall_cnt;
    assign dbg_busy      = r_busy;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: a model dispatch queue feeds the DUT, every instruction
// expected to reach execution is queued in exp_q, and a monitor compares each
// iss_valid && iss_ready transfer against the queue head.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic        flush = 1'b0;
  logic [15:0] stall_cnt;
  logic [31:0] dbg_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] dq_q[$];
  bit          pop_now = 1'b0;

  issue_scoreboard_if ifc ();

  issue_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.slave),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .stall_cnt (stall_cnt),
    .dbg_busy  (dbg_busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    ifc.dq_empty  = 1'b1;
    ifc.dq_instr  = '0;
    ifc.iss_ready = 1'b0;
  end

  // encode an instruction: flags in [31:29], rd [11:7], rs1 [19:15], rs2 [24:20], tag [6:0]
  function automatic logic [31:0] mk(input bit hrd, input bit hrs1, input bit hrs2,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [6:0] tag);
    logic [31:0] v;
    v = '0;
    v[31] = hrd;
    v[30] = hrs1;
    v[29] = hrs2;
    v[11:7] = rd;
    v[19:15] = rs1;
    v[24:20] = rs2;
    v[6:0] = tag;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_dq();
    ifc.dq_empty = (dq_q.size() == 0);
    ifc.dq_instr = (dq_q.size() == 0) ? 32'h0 : dq_q[0];
  endtask

  task automatic push(input logic [31:0] ins);
    dq_q.push_back(ins);
    exp_q.push_back(ins);
    drive_dq();
  endtask

  // advance one clock; inputs may change right after this returns
  task automatic tick();
    logic [31:0] tmp;
    @(posedge clk);
    #1;
    if (pop_now && dq_q.size() != 0) begin
      tmp = dq_q.pop_front();
    end
    drive_dq();
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic wb_clear(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd = r;
    tick();
    wb_valid = 1'b0;
  endtask

  // dispatch queue model: remember whether the head is popped at the coming edge
  always @(negedge clk) begin
    pop_now = rst_n && ifc.dq_r_en;
  end

  // scoreboard monitor: every execution transfer must match the oldest expected entry
  always @(negedge clk) begin
    logic [31:0] want;
    if (rst_n && ifc.iss_valid && ifc.iss_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_order: got %h, expected no transfer", ifc.iss_instr);
      end else begin
        want = exp_q.pop_front();
        if (ifc.iss_instr !== want) begin
          errors++;
          $display("FAIL issue_order: got %h, expected %h", ifc.iss_instr, want);
        end
      end
    end
  end

  initial begin
    logic [31:0] i7;
    logic [31:0] x9;

    // 1: reset with a non-empty queue, then first issue
    push(mk(1, 0, 0, 5'd10, 5'd0, 5'd0, 7'h01));
    ifc.iss_ready = 1'b1;
    settle();
    chk("rst_dq_r_en", {31'b0, ifc.dq_r_en}, 32'd0);
    chk("rst_iss_valid", {31'b0, ifc.iss_valid}, 32'd0);
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    chk("rst_busy", dbg_busy, 32'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("first_pop", {31'b0, ifc.dq_r_en}, 32'd1);
    tick();
    settle();
    chk("first_valid", {31'b0, ifc.iss_valid}, 32'd1);
    chk("first_busy", dbg_busy, 32'h0000_0400);
    tick();
    wb_clear(5'd10);

    // 2: four independent instructions back to back
    for (int i = 1; i <= 4; i++) push(mk(1, 0, 0, 5'(i), 5'd0, 5'd0, 7'(8'h10 + i)));
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("stream_pop", {31'b0, ifc.dq_r_en}, 32'd1);
      tick();
    end
    settle();
    chk("stream_busy", dbg_busy, 32'h0000_001E);
    chk("stream_stall", {16'b0, stall_cnt}, 32'd0);
    tick();
    for (int i = 1; i <= 4; i++) wb_clear(5'(i));

    // 3: RAW dependency released by a same-cycle writeback
    push(mk(1, 1, 0, 5'd5, 5'd0, 5'd0, 7'h21));
    push(mk(1, 1, 1, 5'd6, 5'd5, 5'd5, 7'h22));
    settle();
    chk("raw_producer_pop", {31'b0, ifc.dq_r_en}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("raw_stall", {31'b0, ifc.dq_r_en}, 32'd0);
      tick();
    end
    wb_valid = 1'b1;
    wb_rd = 5'd5;
    settle();
    chk("raw_bypass_pop", {31'b0, ifc.dq_r_en}, 32'd1);
    chk("raw_stall_cnt", {16'b0, stall_cnt}, 32'd3);
    tick();
    wb_valid = 1'b0;
    settle();
    chk("raw_busy_after", dbg_busy, 32'h0000_0040);
    chk("raw_stall_hold", {16'b0, stall_cnt}, 32'd3);
    tick();
    wb_clear(5'd6);

    // 4: backpressure holds the slot, then drain and reload together
    ifc.iss_ready = 1'b0;
    push(mk(1, 0, 0, 5'd7, 5'd0, 5'd0, 7'h31));
    push(mk(1, 0, 0, 5'd8, 5'd0, 5'd0, 7'h32));
    settle();
    chk("bp_first_pop", {31'b0, ifc.dq_r_en}, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_no_pop", {31'b0, ifc.dq_r_en}, 32'd0);
      chk("bp_instr_stable", ifc.iss_instr, mk(1, 0, 0, 5'd7, 5'd0, 5'd0, 7'h31));
      chk("bp_valid_stable", {31'b0, ifc.iss_valid}, 32'd1);
      tick();
    end
    ifc.iss_ready = 1'b1;
    settle();
    chk("bp_drain_reload", {31'b0, ifc.dq_r_en}, 32'd1);
    chk("bp_stall_cnt", {16'b0, stall_cnt}, 32'd6);
    tick();
    settle();
    chk("bp_reloaded", ifc.iss_instr, mk(1, 0, 0, 5'd8, 5'd0, 5'd0, 7'h32));
    tick();
    wb_clear(5'd7);
    wb_clear(5'd8);

    // 5: x0 is never marked busy and never stalls a reader
    push(mk(1, 1, 0, 5'd0, 5'd0, 5'd0, 7'h41));
    push(mk(1, 1, 1, 5'd0, 5'd0, 5'd0, 7'h42));
    settle();
    chk("x0_write_pop", {31'b0, ifc.dq_r_en}, 32'd1);
    tick();
    settle();
    chk("x0_busy", dbg_busy, 32'd0);
    chk("x0_reader_pop", {31'b0, ifc.dq_r_en}, 32'd1);
    tick();
    settle();
    chk("x0_busy_after", dbg_busy, 32'd0);
    chk("x0_stall_cnt", {16'b0, stall_cnt}, 32'd6);
    tick();

    // 6: flush with a held instruction, a full scoreboard and a writeback in flight
    for (int i = 1; i <= 7; i++) push(mk(1, 0, 0, 5'(i), 5'd0, 5'd0, 7'(8'h50 + i)));
    for (int i = 1; i <= 7; i++) tick();
    ifc.iss_ready = 1'b0;
    i7 = mk(1, 0, 0, 5'd7, 5'd0, 5'd0, 7'h57);
    x9 = mk(1, 0, 0, 5'd9, 5'd0, 5'd0, 7'h61);
    push(x9);
    flush = 1'b1;
    wb_valid = 1'b1;
    wb_rd = 5'd3;
    settle();
    chk("flush_busy_before", dbg_busy, 32'h0000_00FE);
    chk("flush_held_instr", ifc.iss_instr, i7);
    chk("flush_no_pop", {31'b0, ifc.dq_r_en}, 32'd0);
    chk("flush_no_stall", {16'b0, stall_cnt}, 32'd6);
    // the held instruction is squashed and never reaches execution
    exp_q.delete(0);
    tick();
    flush = 1'b0;
    wb_valid = 1'b0;
    settle();
    chk("flush_valid", {31'b0, ifc.iss_valid}, 32'd0);
    chk("flush_busy", dbg_busy, 32'd0);
    chk("flush_stall_cnt", {16'b0, stall_cnt}, 32'd6);
    chk("post_flush_pop", {31'b0, ifc.dq_r_en}, 32'd1);
    tick();

    // saturation: a reader of x9 waits behind the held producer for 70000 cycles
    push(mk(1, 1, 0, 5'd11, 5'd9, 5'd0, 7'h62));
    for (int i = 0; i < 70000; i++) tick();
    settle();
    chk("sat_stall_cnt", {16'b0, stall_cnt}, 32'h0000_FFFF);
    chk("sat_no_pop", {31'b0, ifc.dq_r_en}, 32'd0);
    chk("sat_held_instr", ifc.iss_instr, x9);
    chk("sat_busy", dbg_busy, 32'h0000_0200);
    chk("pending_before_reset", exp_q.size(), 32'd2);

    // reset mid-cycle: everything clears at once, nothing is popped
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, ifc.iss_valid}, 32'd0);
    chk("midrst_busy", dbg_busy, 32'd0);
    chk("midrst_stall_cnt", {16'b0, stall_cnt}, 32'd0);
    chk("midrst_dq_r_en", {31'b0, ifc.dq_r_en}, 32'd0);
    chk("midrst_instr", ifc.iss_instr, 32'd0);
    exp_q.delete();
    dq_q.delete();
    drive_dq();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
